// File: rtl/fifo_write_logic_pkg.sv
// rtl/fifo_write_logic_pkg.sv - sizing, packet header offsets and write FSM states for the packet FIFO
package fifo_write_logic_pkg;

  localparam int PTR_SZ    = 2;
  localparam int PTR_IN_SZ = 4;
  localparam int UWIDTH    = 8;
  localparam int MAX_SIZE  = (2 ** PTR_IN_SZ) - 4;

  localparam int SRC_OFS  = 0;
  localparam int DST_OFS  = 1;
  localparam int SIZE_OFS = 2;
  localparam int DATA_OFS = 3;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_RECV   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DROP   = 3'd4
  } wr_state_e;

endpackage

// File: rtl/gray_ptr_reg.sv
// rtl/gray_ptr_reg.sv - binary pointer with a registered gray copy, shared by both FIFO sides
module gray_ptr_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // gray trails bin by one cycle so it only moves after the data it covers is in memory
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      if (inc) bin <= bin + 1'b1;
      gray <= bin ^ (bin >> 1);
    end
  end

endmodule

// File: rtl/fifo_write_logic.sv
// rtl/fifo_write_logic.sv - write-side packet sequencer: length/crc check, slot write, gray commit
module fifo_write_logic
  import fifo_write_logic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [UWIDTH-1:0]    in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 write_en,
  output logic [PTR_SZ-1:0]    waddr,
  output logic [PTR_IN_SZ-1:0] waddr_in,
  output logic [UWIDTH-1:0]    wdata,
  input  logic [PTR_SZ:0]      wq2_rptr,
  output logic [PTR_SZ:0]      wptr_gray,
  output logic                 full,
  output logic                 pkt_drop,
  output logic [7:0]           drop_cnt
);

  wr_state_e             state, state_nx;
  logic [PTR_SZ:0]       wbin;
  logic [PTR_IN_SZ-1:0]  count;
  logic [UWIDTH-1:0]     size, crc_acc;
  logic                  xfer, inc, ptr_settled;
  logic                  is_size_byte, is_crc_byte, bad_size;

  gray_ptr_reg #(.W(PTR_SZ + 1)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .bin  (wbin),
    .gray (wptr_gray)
  );

  assign in_ready     = (state == ST_RECV) || (state == ST_FLUSH);
  assign xfer         = in_valid && in_ready;
  assign inc          = (state == ST_COMMIT);
  assign pkt_drop     = (state == ST_DROP);
  assign full         = (wptr_gray == {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]});
  // the gray copy lags one cycle after a commit; full must not be trusted until it catches up
  assign ptr_settled  = (wptr_gray == (wbin ^ (wbin >> 1)));
  assign is_size_byte = (count == PTR_IN_SZ'(SIZE_OFS));
  assign bad_size     = (in_data == '0) || (in_data > UWIDTH'(MAX_SIZE));
  assign is_crc_byte  = (count > PTR_IN_SZ'(SIZE_OFS)) &&
                        (UWIDTH'(count) == size + UWIDTH'(DATA_OFS));

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_WAIT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_WAIT: begin
        if (!full && ptr_settled) state_nx = ST_RECV;
      end
      ST_RECV: begin
        if (xfer) begin
          if (is_size_byte && bad_size)
            state_nx = in_last ? ST_DROP : ST_FLUSH;
          else if (is_crc_byte)
            state_nx = !in_last ? ST_FLUSH : ((in_data == crc_acc) ? ST_COMMIT : ST_DROP);
          else if (in_last)
            state_nx = ST_DROP;
        end
      end
      ST_FLUSH: begin
        if (xfer && in_last) state_nx = ST_DROP;
      end
      ST_COMMIT: state_nx = ST_WAIT;
      ST_DROP:   state_nx = ST_WAIT;
      default:   state_nx = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      crc_acc  <= '0;
      size     <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      waddr_in <= '0;
      wdata    <= '0;
      drop_cnt <= '0;
    end else begin
      write_en <= 1'b0;
      if (state == ST_WAIT) begin
        count   <= '0;
        crc_acc <= '0;
      end
      if (state == ST_RECV && xfer) begin
        write_en <= 1'b1;
        waddr    <= wbin[PTR_SZ-1:0];
        waddr_in <= count;
        wdata    <= in_data;
        if (!is_crc_byte) begin
          count   <= count + 1'b1;
          crc_acc <= crc_acc ^ in_data;
        end
        if (is_size_byte) size <= in_data;
      end
      if (state == ST_DROP && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_write_logic.sv
// tb/tb_fifo_write_logic.sv - directed bench for the packet FIFO write controller
module tb_fifo_write_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       write_en;
  logic [1:0] waddr;
  logic [3:0] waddr_in;
  logic [7:0] wdata;
  logic [2:0] wq2_rptr;
  logic [2:0] wptr_gray;
  logic       full;
  logic       pkt_drop;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [0:3][0:15];
  int         n_writes = 0;
  int         n_drops  = 0;
  logic [1:0] last_slot;
  logic [3:0] last_ofs;

  logic [7:0] pkt [0:31];
  int         base_w, base_d;

  always #5 clk = ~clk;

  fifo_write_logic dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .write_en  (write_en),
    .waddr     (waddr),
    .waddr_in  (waddr_in),
    .wdata     (wdata),
    .wq2_rptr  (wq2_rptr),
    .wptr_gray (wptr_gray),
    .full      (full),
    .pkt_drop  (pkt_drop),
    .drop_cnt  (drop_cnt)
  );

  // memory model and pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (write_en) begin
      mem[waddr][waddr_in] = wdata;
      n_writes  = n_writes + 1;
      last_slot = waddr;
      last_ofs  = waddr_in;
    end
    if (pkt_drop) n_drops = n_drops + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    base_w = n_writes;
    base_d = n_drops;
    for (int i = 0; i < n; i++) send_byte(pkt[i], (i == n - 1));
  endtask

  // header + incrementing payload + XOR of every preceding byte
  task automatic mk_pkt(input logic [7:0] src, input logic [7:0] dst,
                        input logic [7:0] size, input logic [7:0] seed);
    logic [7:0] x;
    pkt[0] = src;
    pkt[1] = dst;
    pkt[2] = size;
    x = src ^ dst ^ size;
    for (int i = 0; i < int'(size); i++) begin
      pkt[3 + i] = seed + 8'(i);
      x = x ^ pkt[3 + i];
    end
    pkt[3 + int'(size)] = x;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    wq2_rptr = 3'b000;
    tick(3);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_wptr", 32'(wptr_gray), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    tick(1);

    // 1: good packet into slot 0, pointer moves two cycles after the crc handshake
    pkt[0] = 8'h0A; pkt[1] = 8'hA0; pkt[2] = 8'h03;
    pkt[3] = 8'h00; pkt[4] = 8'h01; pkt[5] = 8'h02; pkt[6] = 8'hAA;
    send_pkt(7);
    check("t1_gray_e0", 32'(wptr_gray), 32'b000);
    tick(1);
    check("t1_gray_e1", 32'(wptr_gray), 32'b000);
    tick(1);
    check("t1_gray_e2", 32'(wptr_gray), 32'b001);
    check("t1_writes", 32'(n_writes - base_w), 32'd7);
    check("t1_mem_size", 32'(mem[0][2]), 32'h03);
    check("t1_mem_crc", 32'(mem[0][6]), 32'hAA);
    check("t1_slot", 32'(last_slot), 32'd0);
    check("t1_no_drop", 32'(n_drops - base_d), 32'd0);

    // 2: fill all four slots, then free one
    for (int k = 0; k < 3; k++) begin
      mk_pkt(8'h10 + 8'(k), 8'h20, 8'h02, 8'h40);
      send_pkt(6);
      check("t2_slot", 32'(last_slot), 32'(k + 1));
    end
    tick(4);
    check("t2_gray_full", 32'(wptr_gray), 32'b110);
    check("t2_full", 32'(full), 32'd1);
    check("t2_ready_blocked", 32'(in_ready), 32'd0);
    wq2_rptr = 3'b001;
    #1;
    check("t2_not_full", 32'(full), 32'd0);
    mk_pkt(8'h55, 8'h66, 8'h01, 8'h77);
    send_pkt(5);
    tick(3);
    check("t2_wrap_slot", 32'(last_slot), 32'd0);
    check("t2_gray_5", 32'(wptr_gray), 32'b111);
    wq2_rptr = 3'b111;

    // 3: bad crc drops, slot 1 reused by a max-size packet
    mk_pkt(8'h01, 8'h02, 8'h03, 8'h10);
    pkt[6] = 8'h00;
    send_pkt(7);
    tick(3);
    check("t3_drop_pulse", 32'(n_drops - base_d), 32'd1);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3_gray_hold", 32'(wptr_gray), 32'b111);
    check("t3_bad_slot", 32'(last_slot), 32'd1);
    mk_pkt(8'h03, 8'h04, 8'd12, 8'hC0);
    send_pkt(16);
    tick(3);
    check("t3_max_writes", 32'(n_writes - base_w), 32'd16);
    check("t3_max_slot", 32'(last_slot), 32'd1);
    check("t3_max_ofs", 32'(last_ofs), 32'd15);
    check("t3_max_crc", 32'(mem[1][15]), 32'(pkt[15]));
    check("t3_gray_6", 32'(wptr_gray), 32'b101);

    // 4: oversize header flushes the rest
    mk_pkt(8'h05, 8'h06, 8'h03, 8'h00);
    pkt[2] = 8'h0D;
    send_pkt(10);
    tick(3);
    check("t4_writes", 32'(n_writes - base_w), 32'd3);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
    check("t4_gray_hold", 32'(wptr_gray), 32'b101);

    // 5: short packet, then crc without in_last
    mk_pkt(8'h07, 8'h08, 8'h03, 8'h30);
    send_pkt(6);
    tick(3);
    check("t5a_writes", 32'(n_writes - base_w), 32'd6);
    check("t5a_drop_cnt", 32'(drop_cnt), 32'd3);
    mk_pkt(8'h07, 8'h08, 8'h03, 8'h30);
    pkt[7] = 8'h11;
    pkt[8] = 8'h22;
    send_pkt(9);
    tick(3);
    check("t5b_writes", 32'(n_writes - base_w), 32'd7);
    check("t5b_drops", 32'(n_drops - base_d), 32'd1);
    check("t5b_drop_cnt", 32'(drop_cnt), 32'd4);
    check("t5b_gray_hold", 32'(wptr_gray), 32'b101);

    // drop counter saturation via zero-size packets ending on the size byte
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h00;
    for (int k = 0; k < 260; k++) send_pkt(3);
    tick(3);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);

    // 6: reset mid-packet abandons it
    wq2_rptr = 3'b000;
    mk_pkt(8'h09, 8'h0A, 8'h04, 8'h50);
    for (int i = 0; i < 4; i++) send_byte(pkt[i], 1'b0);
    rst = 1'b0;
    tick(1);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_write_en", 32'(write_en), 32'd0);
    check("t6_waddr_in", 32'(waddr_in), 32'd0);
    check("t6_wdata", 32'(wdata), 32'd0);
    check("t6_wptr", 32'(wptr_gray), 32'd0);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t6_pkt_drop", 32'(pkt_drop), 32'd0);
    rst = 1'b1;
    tick(1);
    mk_pkt(8'h0B, 8'h0C, 8'h02, 8'h90);
    send_pkt(6);
    tick(3);
    check("t6_slot", 32'(last_slot), 32'd0);
    check("t6_mem_data", 32'(mem[0][4]), 32'h91);
    check("t6_gray", 32'(wptr_gray), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
